load_extend_unit: RTL

- Read-side counterpart of the store byte-enable path in the MEM stage.
- Takes a load request (address, width, signedness) and issues a word-aligned read on the data-memory bus with a valid/ready handshake.
- Waits for the response, then selects the addressed byte or halfword and sign- or zero-extends it.
- Holds the result until the pipeline accepts it, and asserts busy to stall the pipeline while the load is in flight.

---
 rtl/load_extend_unit_pkg.sv | 27 ++
 rtl/load_extend_unit_ext.sv | 34 +++
 rtl/load_extend_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/load_extend_unit_pkg.sv
// Shared load/store width codes and load FSM state encoding for the MEM stage.
package load_extend_unit_pkg;

    localparam logic [1:0] LS_b = 2'b00;
    localparam logic [1:0] LS_h = 2'b01;
    localparam logic [1:0] LS_w = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } load_state_t;

    // Unknown width codes behave as word accesses, so they need full alignment too.
    function automatic logic misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (op)
            LS_b:    bad = 1'b0;
            LS_h:    bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend_unit_ext.sv
// load_data_ext: selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_data_ext
    import load_extend_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  ls_op,
    input  logic        ld_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign byte_val = lanes[addr_lo];
    assign half_val = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (ls_op)
            LS_b:    result = {{24{~ld_unsigned & byte_val[7]}}, byte_val};
            LS_h:    result = {{16{~ld_unsigned & half_val[15]}}, half_val};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_extend_unit.sv
// Load path of the MEM stage: word-aligned bus read, lane extraction/extension, result hold.
// Optional misalignment trap enabled by defining LOAD_ALIGN_CHECK_EN.
module load_extend_unit
    import load_extend_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  LS_op,
    input  logic        ld_unsigned,
    input  logic        ld_ack,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    load_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        addr_lo_reg, addr_lo_next;
    logic [1:0]        ls_op_reg, ls_op_next;
    logic              unsigned_reg, unsigned_next;
    logic [29:0]       word_addr_reg, word_addr_next;
    logic [31:0]       rd_data_reg, rd_data_next;
    logic              err_reg, err_next;
    logic [31:0]       ext_data;

    load_data_ext u_ext (
        .word        (bus_rdata),
        .addr_lo     (addr_lo_reg),
        .ls_op       (ls_op_reg),
        .ld_unsigned (unsigned_reg),
        .result      (ext_data)
    );

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_lo_next   = addr_lo_reg;
        ls_op_next     = ls_op_reg;
        unsigned_next  = unsigned_reg;
        word_addr_next = word_addr_reg;
        rd_data_next   = rd_data_reg;
        err_next       = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ld_req) begin
                    addr_lo_next   = ld_addr[1:0];
                    ls_op_next     = LS_op;
                    unsigned_next  = ld_unsigned;
                    word_addr_next = ld_addr[31:2];
`ifdef LOAD_ALIGN_CHECK_EN
                    if (misaligned(LS_op, ld_addr[1:0])) begin
                        rd_data_next = '0;
                        err_next     = 1'b1;
                        state_next   = ST_DONE;
                    end else begin
                        state_next = ST_REQ;
                    end
`else
                    state_next = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the last allowed cycle still beats the timeout.
                if (bus_rvalid) begin
                    rd_data_next = ext_data;
                    err_next     = 1'b0;
                    state_next   = ST_DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    rd_data_next = '0;
                    err_next     = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                if (ld_ack) begin
                    err_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            addr_lo_reg   <= '0;
            ls_op_reg     <= '0;
            unsigned_reg  <= 1'b0;
            word_addr_reg <= '0;
            rd_data_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_lo_reg   <= addr_lo_next;
            ls_op_reg     <= ls_op_next;
            unsigned_reg  <= unsigned_next;
            word_addr_reg <= word_addr_next;
            rd_data_reg   <= rd_data_next;
            err_reg       <= err_next;
        end
    end

    // The requesting instruction must stall in its own cycle, hence the ld_req term.
    always_comb begin
        busy = 1'b0;
        case (state_reg)
            ST_IDLE: busy = ld_req;
            ST_REQ:  busy = 1'b1;
            ST_WAIT: busy = 1'b1;
            ST_DONE: busy = ~ld_ack;
            default: busy = 1'b0;
        endcase
    end

    assign bus_req  = (state_reg == ST_REQ) && !reset;
    assign bus_addr = {word_addr_reg, 2'b00};
    assign rd_valid = (state_reg == ST_DONE);
    assign rd_data  = rd_data_reg;
    assign err      = err_reg;

endmodule
